// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter with run-time frame format and a level-threshold interrupt.
// Defining UART_TX_BREAK_EN enables the break state (line held low while brk=1).
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IRQ_THRESH = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              baud,
  input  logic                    eight,
  input  logic                    parity_en,
  input  logic                    odd_n_even,
  input  logic                    stop2,
  input  logic                    wr_en,
  input  logic [7:0]              wr_data,
  input  logic                    brk,
  input  logic                    irq_ack,
  output logic                    tx,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    irq
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLK_HZ / 300 + 1);
  localparam logic [AW:0] THRESH = CNTW'(IRQ_THRESH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, irq_q, irq_d;
  logic [7:0]    rdData;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, period;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic [3:0]    baud_q, baud_d;
  logic          eight_q, eight_d, parEn_q, parEn_d, stop2_q, stop2_d;
  logic          bitDone, frameEnd, launch, brkReq;
  logic [7:0]    launchData;

`ifdef UART_TX_BREAK_EN
  logic          brkHigh_q, brkHigh_d;
  assign brkReq = brk;
`else
  logic          unusedBrk;
  assign brkReq    = 1'b0;
  assign unusedBrk = brk;
`endif

  assign push   = wr_en & ~full;
  assign rdData = mem_q[rptr_q];
  assign full   = (count_q == CNTW'(DEPTH));
  assign empty  = (count_q == '0);
  assign level  = count_q;
  assign irq    = irq_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Set wins over acknowledge so an edge coinciding with irq_ack is not lost.
  always_comb begin
    irq_d = irq_q;
    if (irq_ack) irq_d = 1'b0;
    if ((count_q > THRESH) && (count_d <= THRESH)) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    case (baud_q)
      4'd0:    period = CW'(CLK_HZ / 300);
      4'd1:    period = CW'(CLK_HZ / 1200);
      4'd2:    period = CW'(CLK_HZ / 2400);
      4'd3:    period = CW'(CLK_HZ / 4800);
      4'd4:    period = CW'(CLK_HZ / 9600);
      4'd5:    period = CW'(CLK_HZ / 19200);
      4'd6:    period = CW'(CLK_HZ / 38400);
      4'd7:    period = CW'(CLK_HZ / 57600);
      4'd8:    period = CW'(CLK_HZ / 115200);
      4'd9:    period = CW'(CLK_HZ / 230400);
      4'd10:   period = CW'(CLK_HZ / 460800);
      default: period = CW'(CLK_HZ / 921600);
    endcase
  end

  assign bitDone    = (cnt_q == period - 1'b1);
  assign launchData = {eight & rdData[7], rdData[6:0]};

  // Frame end re-checks the queue directly so back-to-back frames have no idle gap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = bitDone ? '0 : cnt_q + 1'b1;
    bitIdx_d = bitIdx_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    baud_d   = baud_q;
    eight_d  = eight_q;
    parEn_d  = parEn_q;
    stop2_d  = stop2_q;
    pop      = 1'b0;
    frameEnd = 1'b0;
    launch   = 1'b0;
`ifdef UART_TX_BREAK_EN
    brkHigh_d = brkHigh_q;
`endif
    case (state_q)
      IDLE: frameEnd = 1'b1;
      START: if (bitDone) begin
        state_d  = DATA;
        bitIdx_d = '0;
      end
      DATA: if (bitDone) begin
        shreg_d  = shreg_q >> 1;
        bitIdx_d = bitIdx_q + 1'b1;
        if (bitIdx_q == (eight_q ? 3'd7 : 3'd6)) state_d = parEn_q ? PARITY : STOP1;
      end
      PARITY: if (bitDone) state_d = STOP1;
      STOP1: if (bitDone) begin
        if (stop2_q) state_d = STOP2;
        else         frameEnd = 1'b1;
      end
      STOP2: if (bitDone) frameEnd = 1'b1;
      BREAK: begin
`ifdef UART_TX_BREAK_EN
        if (!brkHigh_q) begin
          cnt_d     = '0;
          brkHigh_d = ~brk;
        end else if (bitDone) begin
          brkHigh_d = 1'b0;
          frameEnd  = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (frameEnd) begin
      if (brkReq) begin
        state_d = BREAK;
        cnt_d   = '0;
        baud_d  = baud;
`ifdef UART_TX_BREAK_EN
        brkHigh_d = 1'b0;
`endif
      end else if (!empty) begin
        launch = 1'b1;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
    if (launch) begin
      pop      = 1'b1;
      state_d  = START;
      cnt_d    = '0;
      shreg_d  = launchData;
      parity_d = (^launchData) ^ odd_n_even;
      baud_d   = baud;
      eight_d  = eight;
      parEn_d  = parity_en;
      stop2_d  = stop2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      baud_q   <= '0;
      eight_q  <= 1'b0;
      parEn_q  <= 1'b0;
      stop2_q  <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brkHigh_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      baud_q   <= baud_d;
      eight_q  <= eight_d;
      parEn_q  <= parEn_d;
      stop2_q  <= stop2_d;
`ifdef UART_TX_BREAK_EN
      brkHigh_q <= brkHigh_d;
`endif
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:  tx = 1'b0;
      DATA:   tx = shreg_q[0];
      PARITY: tx = parity_q;
`ifdef UART_TX_BREAK_EN
      BREAK:  tx = brkHigh_q;
`endif
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized bench for uart_tx_fifo; expected line waveforms are built from frame rules.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int unsigned CLK_HZ = 100000000;
  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [3:0] baud;
    logic       eight;
    logic       par;
    logic       odd;
    logic       stop2;
  } cfg_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    baud = 4'd0;
  logic          eight = 1'b1, parity_en = 1'b0, odd_n_even = 1'b0, stop2 = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          brk = 1'b0, irq_ack = 1'b0;
  logic          tx, full, empty, irq;
  logic [LW-1:0] level;

  int vectors = 0;
  int miscompares = 0;
  int frameNo = 0;
  int modelLevel = 0;
  logic [7:0] modelQ[$];
  cfg_t curCfg;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(CLK_HZ), .DEPTH(DEPTH), .IRQ_THRESH(0)) dut (
    .clk(clk), .rst(rst), .baud(baud), .eight(eight), .parity_en(parity_en),
    .odd_n_even(odd_n_even), .stop2(stop2), .wr_en(wr_en), .wr_data(wr_data),
    .brk(brk), .irq_ack(irq_ack), .tx(tx), .full(full), .empty(empty),
    .level(level), .irq(irq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int period(input logic [3:0] code);
    int unsigned r;
    case (code)
      4'd0: r = 300;     4'd1: r = 1200;    4'd2: r = 2400;    4'd3: r = 4800;
      4'd4: r = 9600;    4'd5: r = 19200;   4'd6: r = 38400;   4'd7: r = 57600;
      4'd8: r = 115200;  4'd9: r = 230400;  4'd10: r = 460800;
      default: r = 921600;
    endcase
    return int'(CLK_HZ / r);
  endfunction

  function automatic cfg_t mkCfg(input logic [3:0] b, input logic e, input logic p,
                                 input logic o, input logic s);
    cfg_t c;
    c.baud = b; c.eight = e; c.par = p; c.odd = o; c.stop2 = s;
    return c;
  endfunction

  function automatic cfg_t randCfg();
    return mkCfg(4'($urandom_range(10, 15)), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
  endfunction

  task automatic setCfg(input cfg_t c);
    baud = c.baud; eight = c.eight; parity_en = c.par; odd_n_even = c.odd; stop2 = c.stop2;
  endtask

  // One push strobe; the model accepts only while it holds fewer than DEPTH bytes.
  task automatic applyStimulus(input logic [7:0] d);
    wr_data = d;
    wr_en = 1'b1;
    if (modelLevel < DEPTH) begin
      modelQ.push_back(d);
      modelLevel++;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic waitStart(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (tx === 1'b0) return;
      @(negedge clk);
    end
    checkOutput("start_timeout", tx, 0);
  endtask

  // Called on the first cycle of a start bit; returns on the first cycle after the last stop bit.
  task automatic checkFrame(input logic [7:0] d, input cfg_t c, input cfg_t nxt);
    bit bits[$];
    int p;
    int nb;
    bit par;
    logic obs;
    bit bad;
    p = period(c.baud);
    nb = c.eight ? 8 : 7;
    par = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(d[i]);
      par ^= d[i];
    end
    if (c.par) bits.push_back(par ^ c.odd);
    bits.push_back(1'b1);
    if (c.stop2) bits.push_back(1'b1);
    frameNo++;
    for (int b = 0; b < bits.size(); b++) begin
      bad = 1'b0;
      obs = tx;
      for (int k = 0; k < p; k++) begin
        if (b == 2 && k == 0) setCfg(nxt);
        if (tx !== bits[b] && !bad) begin
          bad = 1'b1;
          obs = tx;
        end
        @(negedge clk);
      end
      checkOutput($sformatf("frame%0d_bit%0d", frameNo, b), obs, bits[b]);
    end
  endtask

  task automatic checkFrames(input int n, input bit randomCfg);
    cfg_t nxt;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = (modelQ.size() > 0) ? modelQ.pop_front() : 8'h00;
      modelLevel--;
      nxt = randomCfg ? randCfg() : curCfg;
      checkFrame(d, curCfg, nxt);
      curCfg = nxt;
    end
  endtask

  task automatic checkIdle(input string tag, input int cycles);
    logic obs;
    obs = tx;
    for (int i = 0; i < cycles; i++) begin
      if (tx !== 1'b1) obs = tx;
      @(negedge clk);
    end
    checkOutput(tag, obs, 1);
  endtask

  initial begin
    int k;
    int p;
    logic obs;
    curCfg = mkCfg(4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    setCfg(curCfg);
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_irq", irq, 0);
    rst = 1'b1;
    @(negedge clk);

    // 0x55 at 115200 bd, 8N1
    applyStimulus(8'h55);
    checkOutput("t1_tx_before_start", tx, 1);
    checkOutput("t1_level_pushed", level, 1);
    @(negedge clk);
    checkOutput("t1_irq_after_pop", irq, 1);
    checkOutput("t1_empty_after_pop", empty, 1);
    checkFrames(1, 1'b0);
    checkOutput("t1_idle_after", tx, 1);

    // 0xC3, 7 bits, odd parity, two stops; ack coincides with the irq-setting pop
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    checkOutput("t2_irq_cleared", irq, 0);
    curCfg = mkCfg(4'd11, 1'b0, 1'b1, 1'b1, 1'b1);
    setCfg(curCfg);
    applyStimulus(8'hC3);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    checkOutput("t2_irq_set_and_ack", irq, 1);
    checkFrames(1, 1'b0);
    checkOutput("t2_irq_held", irq, 1);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    checkOutput("t2_irq_acked", irq, 0);

    // 17 pushes during an active frame
    curCfg = mkCfg(4'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    setCfg(curCfg);
    applyStimulus(8'hA0);
    fork
      begin
        waitStart(10);
        checkFrames(17, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
          applyStimulus(8'(8'h10 + i));
          if (i == 15) begin
            checkOutput("t3_full_at_16", full, 1);
            checkOutput("t3_level_at_16", level, 16);
          end
        end
        checkOutput("t3_full_after_drop", full, 1);
        checkOutput("t3_level_after_drop", level, 16);
      end
    join
    checkOutput("t3_empty_after", empty, 1);
    checkIdle("t3_no_extra_frame", 2 * period(4'd11) * 10);

    // randomized bursts with configuration changed mid-frame
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, 4);
      curCfg = randCfg();
      setCfg(curCfg);
      fork
        begin
          waitStart(20);
          checkFrames(k, 1'b1);
        end
        begin
          for (int i = 0; i < k; i++) applyStimulus(8'($urandom));
          checkOutput($sformatf("t4_level_r%0d", r), level, (k >= 2) ? k - 1 : k);
        end
      join
      checkOutput($sformatf("t4_empty_r%0d", r), empty, 1);
      checkIdle($sformatf("t4_idle_r%0d", r), 50);
    end

    curCfg = mkCfg(4'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    setCfg(curCfg);
    p = period(4'd11);
`ifdef UART_TX_BREAK_EN
    applyStimulus(8'h3C);
    applyStimulus(8'hE1);
    fork
      begin
        waitStart(10);
        checkFrames(1, 1'b0);
        obs = tx;
        for (int i = 0; i <= 200; i++) begin
          if (tx !== 1'b0) obs = tx;
          if (i == 200) brk = 1'b0;
          @(negedge clk);
        end
        checkOutput("t5_break_low", obs, 0);
        checkIdle("t5_break_high", p);
        checkFrames(1, 1'b0);
      end
      begin
        repeat (300) @(negedge clk);
        brk = 1'b1;
      end
    join
`else
    brk = 1'b1;
    applyStimulus(8'h3C);
    applyStimulus(8'hE1);
    waitStart(10);
    checkFrames(2, 1'b0);
    brk = 1'b0;
`endif
    checkIdle("t5_idle_after", 50);

    // reset during DATA with three entries queued
    for (int i = 0; i < 4; i++) applyStimulus(8'h00);
    repeat (3 * p) @(negedge clk);
    checkOutput("t6_level_before", level, 3);
    rst = 1'b0;
    #1;
    checkOutput("t6_tx", tx, 1);
    checkOutput("t6_level", level, 0);
    checkOutput("t6_empty", empty, 1);
    checkOutput("t6_full", full, 0);
    checkOutput("t6_irq", irq, 0);
    modelQ.delete();
    modelLevel = 0;
    @(negedge clk);
    rst = 1'b1;
    checkIdle("t6_no_frame", 35 * p);
    checkOutput("t6_empty_after", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
